// File: rtl/conv_post_pool_stage.sv
// Post-MAC stage: pipelined partial-sum tree, bias + ReLU + rounded rescale, 2x2/2 pooling.
// Define CONV_AVGPOOL_EN to pool by averaging instead of taking the maximum.
module conv_post_pool_stage #(
  parameter int IFMAP_PAR        = 3,
  parameter int NUM_MULT         = 4,
  parameter int ACCUM_DATA_WIDTH = 32,
  parameter int DATA_WIDTH       = 16,
  parameter int FRAC_SHIFT       = 8,
  parameter int OFMAP_W          = 10,
  parameter int OFMAP_H          = 10,
  parameter int POOL_ADDR_WIDTH  = 6
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         psum_valid,
  input  logic [ACCUM_DATA_WIDTH*IFMAP_PAR*NUM_MULT-1:0] psum_all,
  input  logic [DATA_WIDTH*NUM_MULT-1:0]               bias_all,
  output logic                                         pool_wren,
  output logic [POOL_ADDR_WIDTH-1:0]                   pool_addr,
  output logic [DATA_WIDTH*NUM_MULT-1:0]               pool_data_all,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         sat_flag
);
  localparam int TREE_LAT = (IFMAP_PAR > 1) ? $clog2(IFMAP_PAR) : 0;
  localparam int SW       = ACCUM_DATA_WIDTH + TREE_LAT;
  localparam int VW       = SW + 2;
  localparam int TOTAL    = OFMAP_W * OFMAP_H;
  localparam int PW       = OFMAP_W / 2;
  localparam int PIW      = (PW > 1) ? $clog2(PW) : 1;
  localparam int CW       = $clog2(OFMAP_W + 1);
  localparam int RW       = $clog2(OFMAP_H + 1);
  localparam int NW       = $clog2(TOTAL + 1);
  localparam logic [VW-1:0] RND  = (VW'(1) << FRAC_SHIFT) >> 1;
  localparam logic [VW-1:0] MAXV = VW'({(DATA_WIDTH-1){1'b1}});
`ifdef CONV_AVGPOOL_EN
  localparam int LBW = DATA_WIDTH + 1;
`else
  localparam int LBW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int node_cnt(input int lvl);
    return (IFMAP_PAR + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic [LBW-1:0] pair_f(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef CONV_AVGPOOL_EN
    return LBW'(a) + LBW'(b);
`else
    return (a > b) ? a : b;
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] quad_f(input logic [LBW-1:0] l, input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
`ifdef CONV_AVGPOOL_EN
    logic [DATA_WIDTH+1:0] s;
    s = (DATA_WIDTH+2)'(l) + (DATA_WIDTH+2)'(a) + (DATA_WIDTH+2)'(b);
    return s[DATA_WIDTH+1:2];
`else
    logic [DATA_WIDTH-1:0] p;
    p = pair_f(a, b);
    return (l > p) ? l : p;
`endif
  endfunction

  state_t             state_q;
  logic               busy_q, done_q, sat_q;
  logic [NW-1:0]      pix_cnt_q;
  logic [TREE_LAT:0]  vld_q;
  logic [TREE_LAT+1:0] vchain;
  logic               acc, start_acc, post_v;

  assign acc       = psum_valid && (state_q == RUN);
  assign start_acc = start && (state_q == IDLE);
  assign vchain    = {vld_q, acc};
  assign post_v    = vld_q[TREE_LAT];

  // Level 0 is the raw DSP results; each later level registers pairwise sums, odd node passes through.
  for (genvar gi = 0; gi <= TREE_LAT; gi++) begin : g_lvl
    for (genvar gj = 0; gj < IFMAP_PAR; gj++) begin : g_node
      if (gj < node_cnt(gi)) begin : g_on
        logic signed [SW-1:0] q [NUM_MULT];
        if (gi == 0) begin : g_leaf
          for (genvar gm = 0; gm < NUM_MULT; gm++) begin : g_m
            assign q[gm] = SW'($signed(psum_all[(gm*IFMAP_PAR+gj)*ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH]));
          end
        end else if (2*gj+1 < node_cnt(gi-1)) begin : g_add
          always_ff @(posedge clock or negedge reset) begin
            for (int m = 0; m < NUM_MULT; m++)
              if (!reset) q[m] <= '0;
              else q[m] <= g_lvl[gi-1].g_node[2*gj].g_on.q[m] + g_lvl[gi-1].g_node[2*gj+1].g_on.q[m];
          end
        end else begin : g_pass
          always_ff @(posedge clock or negedge reset) begin
            for (int m = 0; m < NUM_MULT; m++)
              if (!reset) q[m] <= '0;
              else q[m] <= g_lvl[gi-1].g_node[2*gj].g_on.q[m];
          end
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] pix_d [NUM_MULT];
  logic [NUM_MULT-1:0]   sat_d;
  for (genvar gi = 0; gi < NUM_MULT; gi++) begin : g_post
    logic signed [VW-1:0] v;
    logic [VW-1:0]        r;
    always_comb begin
      v = VW'(g_lvl[TREE_LAT].g_node[0].g_on.q[gi]) + VW'($signed(bias_all[gi*DATA_WIDTH +: DATA_WIDTH]));
      if (v < 0) v = '0;
      r = ($unsigned(v) + RND) >> FRAC_SHIFT;
    end
    assign sat_d[gi] = (r > MAXV);
    assign pix_d[gi] = sat_d[gi] ? MAXV[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
  end

  logic [DATA_WIDTH-1:0] post_q [NUM_MULT];
  logic                  post_sat_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q      <= '0;
      post_sat_q <= 1'b0;
      for (int m = 0; m < NUM_MULT; m++) post_q[m] <= '0;
    end else begin
      vld_q      <= vchain[TREE_LAT:0];
      post_sat_q <= |sat_d;
      post_q     <= pix_d;
    end
  end

  logic [CW-1:0]              col_q;
  logic [RW-1:0]              row_q;
  logic [DATA_WIDTH-1:0]      hold_q [NUM_MULT];
  logic [LBW-1:0]             lbuf_q [NUM_MULT][PW];
  logic                       wren_q;
  logic [POOL_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]      data_q [NUM_MULT];
  logic [PIW-1:0]             lb_idx;
  logic                       in_win;

  assign lb_idx = PIW'(col_q >> 1);
  // Trailing odd column/row falls outside every window and is simply consumed.
  assign in_win = (col_q < CW'(2*PW)) && (row_q < RW'(2*(OFMAP_H/2)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q  <= '0;
      row_q  <= '0;
      wren_q <= 1'b0;
      addr_q <= '0;
      for (int m = 0; m < NUM_MULT; m++) begin
        hold_q[m] <= '0;
        data_q[m] <= '0;
        for (int k = 0; k < PW; k++) lbuf_q[m][k] <= '0;
      end
    end else begin
      wren_q <= 1'b0;
      if (start_acc) begin
        col_q <= '0;
        row_q <= '0;
      end else if (post_v) begin
        if (col_q == CW'(OFMAP_W-1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (in_win) begin
          if (!col_q[0]) begin
            hold_q <= post_q;
          end else if (!row_q[0]) begin
            for (int m = 0; m < NUM_MULT; m++) lbuf_q[m][lb_idx] <= pair_f(hold_q[m], post_q[m]);
          end else begin
            wren_q <= 1'b1;
            addr_q <= POOL_ADDR_WIDTH'(int'(row_q >> 1) * PW + int'(col_q >> 1));
            for (int m = 0; m < NUM_MULT; m++) data_q[m] <= quad_f(lbuf_q[m][lb_idx], hold_q[m], post_q[m]);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      pix_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (post_v && post_sat_q) sat_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= RUN;
          busy_q    <= 1'b1;
          pix_cnt_q <= '0;
          sat_q     <= 1'b0;
        end
        RUN: if (psum_valid) begin
          if (pix_cnt_q == NW'(TOTAL-1)) state_q <= DRAIN;
          pix_cnt_q <= pix_cnt_q + 1'b1;
        end
        DRAIN: if (vld_q == '0) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pool_wren = wren_q;
  assign pool_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_flag  = sat_q;
  for (genvar gi = 0; gi < NUM_MULT; gi++) begin : g_out
    assign pool_data_all[gi*DATA_WIDTH +: DATA_WIDTH] = data_q[gi];
  end
endmodule

// File: tb/tb_conv_post_pool_stage.sv
// Scoreboard bench for conv_post_pool_stage: a behavioural model pushes expected pool writes, a monitor pops them.
module tb_conv_post_pool_stage;
  localparam int IP = 3, NM = 2, AW = 32, DW = 16, FS = 8, W = 4, H = 4, PAW = 6;
  localparam int ND = IP*NM, NPIX = W*H, NWIN = (W/2)*(H/2);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, psum_valid = 1'b0;
  logic [AW*ND-1:0] psum_all = '0;
  logic [DW*NM-1:0] bias_all = '0;
  logic pool_wren, busy, done, sat_flag;
  logic [PAW-1:0] pool_addr;
  logic [DW*NM-1:0] pool_data_all;

  conv_post_pool_stage #(
    .IFMAP_PAR(IP), .NUM_MULT(NM), .ACCUM_DATA_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_SHIFT(FS),
    .OFMAP_W(W), .OFMAP_H(H), .POOL_ADDR_WIDTH(PAW)
  ) dut (
    .clock(clk), .reset(rst_n), .start(start), .psum_valid(psum_valid), .psum_all(psum_all),
    .bias_all(bias_all), .pool_wren(pool_wren), .pool_addr(pool_addr), .pool_data_all(pool_data_all),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PAW-1:0]   addr;
    logic [DW*NM-1:0] data;
  } wr_t;

  int  n_checks = 0, n_fail = 0;
  int  cyc = 0, last_wr_cyc = -100, wr_cnt = 0;
  int  tab [NPIX][ND];
  int  bias [NM];
  bit  exp_sat;
  wr_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every pool write is matched against the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && pool_wren) begin
      wr_t e;
      wr_cnt++;
      last_wr_cyc = cyc;
      $display("write addr=%0d data=%h", pool_addr, pool_data_all);
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", pool_addr, e.addr);
        for (int m = 0; m < NM; m++) check("wr_data", pool_data_all[m*DW +: DW], e.data[m*DW +: DW]);
      end
    end
  end

  // Reference: per-pixel arithmetic from the rules, then window max/average over the 2x2 blocks.
  task automatic model_map();
    longint post [NPIX][NM];
    longint s, a, b, c, d, v;
    wr_t e;
    exp_sat = 0;
    for (int p = 0; p < NPIX; p++)
      for (int m = 0; m < NM; m++) begin
        s = bias[m];
        for (int i = 0; i < IP; i++) s += tab[p][m*IP+i];
        if (s < 0) s = 0;
        s = (s + ((longint'(1) << FS) / 2)) / (longint'(1) << FS);
        if (s > 32767) begin s = 32767; exp_sat = 1; end
        post[p][m] = s;
      end
    for (int wr = 0; wr < H/2; wr++)
      for (int wc = 0; wc < W/2; wc++) begin
        e.addr = PAW'(wr*(W/2) + wc);
        e.data = '0;
        for (int m = 0; m < NM; m++) begin
          a = post[(2*wr)*W + 2*wc][m];
          b = post[(2*wr)*W + 2*wc+1][m];
          c = post[(2*wr+1)*W + 2*wc][m];
          d = post[(2*wr+1)*W + 2*wc+1][m];
`ifdef CONV_AVGPOOL_EN
          v = (a + b + c + d) / 4;
`else
          v = a;
          if (b > v) v = b;
          if (c > v) v = c;
          if (d > v) v = d;
`endif
          e.data[m*DW +: DW] = DW'(v);
        end
        exp_q.push_back(e);
      end
  endtask

  task automatic drive_pixel(input int p);
    for (int k = 0; k < ND; k++) psum_all[k*AW +: AW] = tab[p][k];
    psum_valid = 1'b1;
    @(posedge clk); #1;
    psum_valid = 1'b0;
  endtask

  task automatic run_map(input int gaps, input bit dup_start, input int extra);
    int t;
    model_map();
    wr_cnt = 0;
    for (int m = 0; m < NM; m++) bias_all[m*DW +: DW] = DW'(bias[m]);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_run", busy, 1);
    for (int p = 0; p < NPIX; p++) begin
      if (gaps > 0) repeat ($urandom_range(0, gaps)) @(posedge clk);
      #0 start = dup_start && (p == 5);
      drive_pixel(p);
      start = 1'b0;
    end
    for (int x = 0; x < extra; x++) begin
      psum_all = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      psum_valid = 1'b1;
      @(posedge clk); #1;
      psum_valid = 1'b0;
    end
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_timeout", t < 200, 1);
    check("done_after_last_write", cyc - last_wr_cyc, 1);
    check("write_count", wr_cnt, NWIN);
    check("sat_flag", sat_flag, exp_sat);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_wren", pool_wren, 0);
    check("rst_addr", pool_addr, 0);
    check("rst_data", pool_data_all, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
  endtask

  task automatic fill_random(input int span);
    for (int p = 0; p < NPIX; p++)
      for (int k = 0; k < ND; k++) tab[p][k] = int'($urandom_range(0, 2*span)) - span;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;

    // ch0 partials sum to 6 after rescale; ch1 goes negative and is clamped by ReLU.
    for (int p = 0; p < NPIX; p++) begin
      tab[p][0] = 256; tab[p][1] = 512; tab[p][2] = 768;
      tab[p][3] = -2560; tab[p][4] = 0; tab[p][5] = 0;
    end
    bias[0] = 0; bias[1] = 3;
    run_map(0, 0, 0);

    // Rounding: 0x180 -> 2, 0x17F -> 1.
    for (int p = 0; p < NPIX; p++) begin
      for (int k = 0; k < ND; k++) tab[p][k] = 0;
      tab[p][0] = 'h180; tab[p][3] = 'h17F;
    end
    bias[0] = 0; bias[1] = 0;
    run_map(0, 0, 0);

    // Saturation on ch0.
    for (int p = 0; p < NPIX; p++) tab[p][0] = 'h7FFF_FF00;
    run_map(0, 0, 0);

    // Raster ramp on ch0, small random ch1; sat_flag must be cleared by the new start.
    fill_random(65536);
    for (int p = 0; p < NPIX; p++) begin
      tab[p][0] = p * 256; tab[p][1] = 0; tab[p][2] = 0;
    end
    run_map(0, 0, 0);

    // Random maps with gaps, start pulsed while busy and surplus beats.
    for (int n = 0; n < 4; n++) begin
      fill_random(1 << 22);
      for (int m = 0; m < NM; m++) bias[m] = int'($urandom_range(0, 65535)) - 32768;
      run_map(3, 1, 3);
    end

    // Abort a map after 7 pixels with reset, then run a complete one.
    fill_random(1 << 22);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int p = 0; p < 7; p++) drive_pixel(p);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_random(1 << 22);
    run_map(2, 0, 0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_post_pool_stage.md
Name: conv_post_pool_stage

Overview:
Parametrised post-MAC stage for the CNN conv layers. It takes NUM_DSP raw DSP accumulator results per valid beat and reduces each group of IFMAP_PAR partials with a pipelined adder tree of any IFMAP_PAR. It then adds a per-channel bias, applies ReLU, rescales with rounding and saturation, and 2x2 stride-2 pools a raster-ordered OFMAP_W x OFMAP_H map. Results for all NUM_MULT output channels are written in parallel to the pool memories. It replaces the fixed 3-input sum, relu_param and pool_* chain used per layer.

Parameters:
IFMAP_PAR, 3, input-map partials summed per output channel (>=1)
NUM_MULT, 4, output channels processed in parallel
ACCUM_DATA_WIDTH, 32, width of each DSP result (signed)
DATA_WIDTH, 16, output pixel width (signed, non-negative after ReLU)
FRAC_SHIFT, 8, arithmetic right shift applied before saturation
OFMAP_W, 10, conv output width in pixels
OFMAP_H, 10, conv output height in pixels
POOL_ADDR_WIDTH, 6, pool memory address width
(derived) NUM_DSP = IFMAP_PAR*NUM_MULT; TREE_LAT = clog2(IFMAP_PAR), 0 when IFMAP_PAR=1

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
start  in  1  one-cycle pulse, begins a new output map
psum_valid  in  1  psum_all holds one conv pixel for all channels
psum_all  in  ACCUM_DATA_WIDTH*NUM_DSP  DSP results; dsp k = channel k/IFMAP_PAR
bias_all  in  DATA_WIDTH*NUM_MULT  signed bias per channel, LSB-aligned to accumulator; held stable while busy
pool_wren  out  1  write strobe to pool memories
pool_addr  out  POOL_ADDR_WIDTH  write address, shared by all channels
pool_data_all  out  DATA_WIDTH*NUM_MULT  pooled pixel per channel
busy  out  1  high from start accepted until done
done  out  1  one-cycle pulse after last pool write
sat_flag  out  1  sticky: any saturation since last start

Behaviour:
- Reset (asserted low, async): all outputs are 0; FSM goes to IDLE; pipeline valids, counters, line buffer valid and sat_flag are cleared. Reset mid-map abandons the map with no further writes.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN; clears the pixel counter and sat_flag. psum_valid is ignored in IDLE.
  - RUN: accepts exactly OFMAP_W*OFMAP_H psum_valid beats. After the last beat -> DRAIN; further psum_valid beats are ignored.
  - DRAIN: waits until the pipeline is empty and the final pool write has issued -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - busy=1 in RUN, DRAIN and DONE. start while busy is ignored.
- Adder tree: registered binary tree over IFMAP_PAR inputs, TREE_LAT stages. Odd operands pass through a register. Internal width is ACCUM_DATA_WIDTH+TREE_LAT, so no overflow is possible.
- Post stage (1 register): v = sum + sign_extend(bias). If v<0, v=0 (ReLU). Then r = (v + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (round half up; no rounding term when FRAC_SHIFT=0). If r > 2^(DATA_WIDTH-1)-1, output max positive and set sat_flag.
- Latency from psum_valid to post-pixel valid is TREE_LAT+1 cycles. Valid bubbles propagate unchanged; no back-pressure.
- Pool (raster order, row r, column c counters):
  - r even, c even: hold pixel.
  - r even, c odd: line_buf[c/2] = max(hold, pixel), per channel.
  - r odd, c even: hold pixel.
  - r odd, c odd: the next cycle drives pool_wren=1, pool_addr=(r/2)*(OFMAP_W/2)+c/2, pool_data = max(line_buf[c/2], hold, pixel).
  - Odd OFMAP_W or OFMAP_H: trailing column/row pixels are consumed but dropped.
  - Column wraps at OFMAP_W-1; row increments on wrap. The line buffer is OFMAP_W/2 x DATA_WIDTH x NUM_MULT registers.
- pool_wren is high for exactly one cycle per pooled pixel, (OFMAP_W/2)*(OFMAP_H/2) writes per map. pool_addr and pool_data hold their last values when pool_wren is low.

Optional Feature:
CONV_AVGPOOL_EN. When defined, pooling is average: per window, the four post pixels are summed at DATA_WIDTH+2 bits and the result is >>2 (truncate). The line buffer stores the pair sum at DATA_WIDTH+1 bits. When undefined, pooling is max as above. Latency and addressing are identical in both modes.

Test Plan:
- IFMAP_PAR=3, NUM_MULT=2, W=H=4, FRAC_SHIFT=0, bias 0. Ch0 partials 1,2,3 on every pixel -> 4 writes at addr 0..3, all data 6. done is high one cycle after the 4th write.
- Same config, ch1 partials (-10,0,0) with bias 3 -> ReLU clamps; ch1 writes 0 and sat_flag stays 0.
- FRAC_SHIFT=8, sum 0x0180 -> 2 (round up); sum 0x017F -> 1. Sum 0x7FFF_FF00 -> 0x7FFF with sat_flag=1. sat_flag clears on the next start.
- Ch0 map values 0..15 in raster order -> writes 5, 7, 13, 15 (max mode). With CONV_AVGPOOL_EN -> 2, 4, 10, 12.
- Flow control and start handling:
  - Random psum_valid gaps -> same results.
  - start pulsed while busy -> ignored.
  - 3 extra psum_valid beats after 16 -> no extra writes.
- reset low after 7 pixels, released, then a full new map -> exactly 4 writes, none from the aborted map, all correct.
